// File: rtl/associative_memory_search.sv
// associative_memory_search
//   Classification stage behind the temporal encoder. It accepts one query
//   hypervector, walks the NUM_CLASSES stored prototypes one per cycle, and
//   returns the index and Hamming distance of the nearest prototype.
//   Prototypes are loaded through a write port that commits only while idle.
//
//   Optional feature macro: AM_REJECT_EN. When defined, a result whose best
//   distance exceeds REJECT_THRESHOLD is reported with LabelOut_DO equal to
//   NUM_CLASSES (reject code). DistanceOut_DO still carries the true distance.
//
//   HV_DIMENSION defaults to 2000, the project-wide hypervector width.
//
// Ports
//   Clk_CI            clock, rising edge
//   Reset_RI          synchronous active-high reset
//   ValidIn_SI        query valid
//   ReadyOut_SO       block can accept a query (high only in IDLE)
//   HypervectorIn_DI  query hypervector
//   ProtoWrEn_SI      prototype write strobe
//   ProtoWrAddr_DI    prototype index to write (>= NUM_CLASSES ignored)
//   ProtoWrData_DI    prototype data
//   ValidOut_SO       result valid
//   ReadyIn_SI        downstream accepts result
//   LabelOut_DO       winning class index (or reject code)
//   DistanceOut_DO    Hamming distance of the winner
module associative_memory_search #(
  parameter int HV_DIMENSION = 2000,
  parameter int NUM_CLASSES  = 5,
  parameter int DIST_W       = $clog2(HV_DIMENSION) + 1,
  parameter int LABEL_W      = $clog2(NUM_CLASSES) + 1
`ifdef AM_REJECT_EN
  ,
  parameter int REJECT_THRESHOLD = HV_DIMENSION / 2
`endif
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RI,
  input  logic                    ValidIn_SI,
  output logic                    ReadyOut_SO,
  input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
  input  logic                    ProtoWrEn_SI,
  input  logic [LABEL_W-1:0]      ProtoWrAddr_DI,
  input  logic [0:HV_DIMENSION-1] ProtoWrData_DI,
  output logic                    ValidOut_SO,
  input  logic                    ReadyIn_SI,
  output logic [LABEL_W-1:0]      LabelOut_DO,
  output logic [DIST_W-1:0]       DistanceOut_DO
);

  localparam int IDX_W = $clog2(NUM_CLASSES);
  localparam logic [LABEL_W-1:0] NUM_CLASSES_L = LABEL_W'(NUM_CLASSES);
  localparam logic [LABEL_W-1:0] LAST_CLASS    = LABEL_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t                    state;
  logic [LABEL_W-1:0]        counter;
  logic [0:HV_DIMENSION-1]   query;
  logic [0:HV_DIMENSION-1]   proto_mem [NUM_CLASSES];
  logic [DIST_W-1:0]         best_dist;
  logic [LABEL_W-1:0]        best_label;

  logic [DIST_W-1:0]         dist_cur;
  logic [DIST_W-1:0]         best_dist_nxt;
  logic [LABEL_W-1:0]        best_label_nxt;
  logic [LABEL_W-1:0]        label_final;
  logic                      wr_ok;

  // Distance never exceeds HV_DIMENSION, which DIST_W is sized to hold.
  function automatic logic [DIST_W-1:0] popcount(input logic [0:HV_DIMENSION-1] v);
    logic [DIST_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < HV_DIMENSION; i++) begin
      cnt = cnt + DIST_W'(v[i]);
    end
    return cnt;
  endfunction

  always_comb begin
    dist_cur       = popcount(query ^ proto_mem[counter[IDX_W-1:0]]);
    best_dist_nxt  = best_dist;
    best_label_nxt = best_label;
    // Strict less-than: on a tie the earlier (lower) index is kept.
    if (dist_cur < best_dist) begin
      best_dist_nxt  = dist_cur;
      best_label_nxt = counter;
    end
    label_final = best_label_nxt;
`ifdef AM_REJECT_EN
    if (best_dist_nxt > DIST_W'(REJECT_THRESHOLD)) begin
      label_final = NUM_CLASSES_L;
    end
`endif
    wr_ok = ProtoWrEn_SI && (ProtoWrAddr_DI < NUM_CLASSES_L);
  end

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      state          <= IDLE;
      counter        <= '0;
      query          <= '0;
      best_dist      <= '1;
      best_label     <= '0;
      ReadyOut_SO    <= 1'b1;
      ValidOut_SO    <= 1'b0;
      LabelOut_DO    <= '0;
      DistanceOut_DO <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        proto_mem[c] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          // A write in the accepting cycle lands before the first compare,
          // so the search sees the new prototype.
          if (wr_ok) begin
            proto_mem[ProtoWrAddr_DI[IDX_W-1:0]] <= ProtoWrData_DI;
          end
          if (ValidIn_SI) begin
            query       <= HypervectorIn_DI;
            counter     <= '0;
            best_dist   <= '1;
            best_label  <= '0;
            ReadyOut_SO <= 1'b0;
            state       <= SEARCH;
          end
        end
        // One prototype compared per cycle; the last compare feeds the
        // result registers directly.
        SEARCH: begin
          best_dist  <= best_dist_nxt;
          best_label <= best_label_nxt;
          if (counter == LAST_CLASS) begin
            counter        <= '0;
            ValidOut_SO    <= 1'b1;
            LabelOut_DO    <= label_final;
            DistanceOut_DO <= best_dist_nxt;
            state          <= DONE;
          end else begin
            counter <= counter + LABEL_W'(1);
          end
        end
        // Result held until downstream takes it; outputs keep their values
        // after the handshake.
        DONE: begin
          if (ReadyIn_SI) begin
            ValidOut_SO <= 1'b0;
            ReadyOut_SO <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_associative_memory_search.sv
// tb_associative_memory_search
//   Self-checking bench for associative_memory_search. A behavioural model
//   keeps its own copy of the prototypes and finds the nearest one with
//   $countones; each scenario task drives stimulus and checks inline.
//   Define AM_REJECT_EN for both files to exercise the reject feature with
//   REJECT_THRESHOLD = 100.
module tb_associative_memory_search;

  localparam int HV  = 2000;
  localparam int NC  = 5;
  localparam int DW  = $clog2(HV) + 1;
  localparam int LW  = $clog2(NC) + 1;
  localparam int THR = 100;

  logic          Clk_CI = 1'b0;
  logic          Reset_RI;
  logic          ValidIn_SI;
  logic          ReadyOut_SO;
  logic [0:HV-1] HypervectorIn_DI;
  logic          ProtoWrEn_SI;
  logic [LW-1:0] ProtoWrAddr_DI;
  logic [0:HV-1] ProtoWrData_DI;
  logic          ValidOut_SO;
  logic          ReadyIn_SI;
  logic [LW-1:0] LabelOut_DO;
  logic [DW-1:0] DistanceOut_DO;

  int n_checks = 0;
  int n_fail   = 0;

  logic [0:HV-1] model_proto [NC];

  always #5 Clk_CI = ~Clk_CI;

`ifdef AM_REJECT_EN
  associative_memory_search #(.HV_DIMENSION(HV), .NUM_CLASSES(NC), .REJECT_THRESHOLD(THR)) dut (
`else
  associative_memory_search #(.HV_DIMENSION(HV), .NUM_CLASSES(NC)) dut (
`endif
    .Clk_CI(Clk_CI), .Reset_RI(Reset_RI), .ValidIn_SI(ValidIn_SI), .ReadyOut_SO(ReadyOut_SO),
    .HypervectorIn_DI(HypervectorIn_DI), .ProtoWrEn_SI(ProtoWrEn_SI),
    .ProtoWrAddr_DI(ProtoWrAddr_DI), .ProtoWrData_DI(ProtoWrData_DI),
    .ValidOut_SO(ValidOut_SO), .ReadyIn_SI(ReadyIn_SI),
    .LabelOut_DO(LabelOut_DO), .DistanceOut_DO(DistanceOut_DO));

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void model_search(input logic [0:HV-1] q, output int lbl, output int dst);
    int best;
    int d;
    best = HV + 1;
    lbl  = 0;
    for (int c = 0; c < NC; c++) begin
      d = $countones(q ^ model_proto[c]);
      if (d < best) begin
        best = d;
        lbl  = c;
      end
    end
    dst = best;
`ifdef AM_REJECT_EN
    if (best > THR) lbl = NC;
`endif
  endfunction

  function automatic logic [0:HV-1] rand_hv();
    logic [0:HV-1] v;
    for (int i = 0; i < HV; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic logic [0:HV-1] ones_prefix(input int n);
    logic [0:HV-1] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge Clk_CI);
    #1;
  endtask

  task automatic do_reset();
    Reset_RI = 1'b1;
    tick();
    tick();
    Reset_RI = 1'b0;
    for (int c = 0; c < NC; c++) model_proto[c] = '0;
  endtask

  // Issued while idle; the model applies the same address filter.
  task automatic write_proto(input int addr, input logic [0:HV-1] data);
    ProtoWrEn_SI   = 1'b1;
    ProtoWrAddr_DI = LW'(addr);
    ProtoWrData_DI = data;
    tick();
    ProtoWrEn_SI = 1'b0;
    if (addr < NC) model_proto[addr] = data;
  endtask

  // Returns with the accepting edge just behind us.
  task automatic start_query(input logic [0:HV-1] q);
    int n;
    n = 0;
    while (ReadyOut_SO !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    n_checks++;
    if (ReadyOut_SO !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_timeout: ReadyOut_SO=%b after %0d cycles, required 1", ReadyOut_SO, n);
    end
    ValidIn_SI       = 1'b1;
    HypervectorIn_DI = q;
    tick();
    ValidIn_SI = 1'b0;
  endtask

  // Edges counted from the accepting edge until ValidOut_SO is seen; -1 on timeout.
  task automatic wait_result(output int lat);
    lat = 0;
    while (ValidOut_SO !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    if (ValidOut_SO !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL result_timeout: ValidOut_SO=%b after %0d cycles, required 1", ValidOut_SO, lat);
      lat = -1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (ValidOut_SO !== 1'b0 || ReadyOut_SO !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_handshake: valid=%b ready=%b, required valid=0 ready=1", ValidOut_SO, ReadyOut_SO);
    end
    n_checks++;
    if (LabelOut_DO !== '0 || DistanceOut_DO !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: label=%0d dist=%0d, required 0 0", LabelOut_DO, DistanceOut_DO);
    end
  endtask

  task automatic test_spec_vector();
    int lat;
    write_proto(0, '0);
    write_proto(1, '1);
    for (int c = 2; c < NC; c++) write_proto(c, ones_prefix(HV / 2));
    ReadyIn_SI = 1'b1;
    start_query(ones_prefix(10));
    n_checks++;
    if (ValidOut_SO !== 1'b0) begin
      n_fail++;
      $display("FAIL spec_early_valid: ValidOut_SO=%b right after accept, required 0", ValidOut_SO);
    end
    wait_result(lat);
    // Seen after NC edges past the accepting edge, i.e. NC+1 cycles counting
    // the cycle that presented the query.
    n_checks++;
    if (lat != NC) begin
      n_fail++;
      $display("FAIL spec_latency: %0d edges after accept, required %0d", lat, NC);
    end
    n_checks++;
    if (LabelOut_DO !== LW'(0) || DistanceOut_DO !== DW'(10)) begin
      n_fail++;
      $display("FAIL spec_result: label=%0d dist=%0d, required 0 10", LabelOut_DO, DistanceOut_DO);
    end
    tick();
    n_checks++;
    if (ValidOut_SO !== 1'b0 || ReadyOut_SO !== 1'b1 || LabelOut_DO !== LW'(0) || DistanceOut_DO !== DW'(10)) begin
      n_fail++;
      $display("FAIL spec_after_handshake: valid=%b ready=%b label=%0d dist=%0d, required 0 1 0 10",
               ValidOut_SO, ReadyOut_SO, LabelOut_DO, DistanceOut_DO);
    end
  endtask

  task automatic test_tie();
    logic [0:HV-1] q;
    int lat;
    q = rand_hv();
    q[0] = 1'b0;
    write_proto(0, '1);
    write_proto(1, '1);
    write_proto(2, q);
    write_proto(3, q);
    write_proto(4, '1);
    start_query(q);
    wait_result(lat);
    n_checks++;
    if (LabelOut_DO !== LW'(2) || DistanceOut_DO !== DW'(0)) begin
      n_fail++;
      $display("FAIL tie_result: label=%0d dist=%0d, required 2 0", LabelOut_DO, DistanceOut_DO);
    end
    tick();
  endtask

  task automatic test_random();
    logic [0:HV-1] q;
    int el, ed, lat, nflip, dly;
    for (int it = 0; it < 8; it++) begin
      for (int c = 0; c < NC; c++) write_proto(c, rand_hv());
      q = model_proto[$urandom_range(0, NC - 1)];
      nflip = $urandom_range(0, 400);
      for (int k = 0; k < nflip; k++) begin
        int idx;
        idx = $urandom_range(0, HV - 1);
        q[idx] = ~q[idx];
      end
      // Out-of-range address carrying the query itself; must not land anywhere.
      write_proto($urandom_range(NC, (1 << LW) - 1), q);
      model_search(q, el, ed);
      dly = $urandom_range(0, 3);
      ReadyIn_SI = (dly == 0);
      start_query(q);
      wait_result(lat);
      n_checks++;
      if (lat != NC || LabelOut_DO !== LW'(el) || DistanceOut_DO !== DW'(ed)) begin
        n_fail++;
        $display("FAIL random_%0d: lat=%0d label=%0d dist=%0d, required lat=%0d label=%0d dist=%0d",
                 it, lat, LabelOut_DO, DistanceOut_DO, NC, el, ed);
      end
      for (int k = 0; k < dly; k++) tick();
      ReadyIn_SI = 1'b1;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [0:HV-1] q1, q2;
    int e1l, e1d, e2l, e2d, acc, lat, l1, d1;
    logic r, got1;
    q1 = model_proto[1] ^ ones_prefix(37);
    q2 = rand_hv();
    model_search(q1, e1l, e1d);
    model_search(q2, e2l, e2d);
    ReadyIn_SI = 1'b1;
    ValidIn_SI = 1'b1;
    HypervectorIn_DI = q1;
    tick();
    HypervectorIn_DI = q2;
    acc = 0;
    got1 = 1'b0;
    l1 = -1;
    d1 = -1;
    for (int n = 1; n <= 30 && acc == 0; n++) begin
      r = ReadyOut_SO;
      tick();
      if (!got1 && ValidOut_SO === 1'b1) begin
        got1 = 1'b1;
        l1 = int'(LabelOut_DO);
        d1 = int'(DistanceOut_DO);
      end
      if (r === 1'b1) acc = n;
    end
    ValidIn_SI = 1'b0;
    n_checks++;
    if (acc != NC + 2) begin
      n_fail++;
      $display("FAIL b2b_interval: second accept %0d cycles after first, required %0d", acc, NC + 2);
    end
    n_checks++;
    if (l1 != e1l || d1 != e1d) begin
      n_fail++;
      $display("FAIL b2b_first: label=%0d dist=%0d, required %0d %0d", l1, d1, e1l, e1d);
    end
    wait_result(lat);
    n_checks++;
    if (LabelOut_DO !== LW'(e2l) || DistanceOut_DO !== DW'(e2d)) begin
      n_fail++;
      $display("FAIL b2b_second: label=%0d dist=%0d, required %0d %0d", LabelOut_DO, DistanceOut_DO, e2l, e2d);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [0:HV-1] q1, q2;
    int e1l, e1d, e2l, e2d, lat;
    logic [LW-1:0] l;
    logic [DW-1:0] d;
    logic stable;
    q1 = model_proto[3] ^ ones_prefix(5);
    q2 = model_proto[0] ^ ones_prefix(3);
    model_search(q1, e1l, e1d);
    model_search(q2, e2l, e2d);
    ReadyIn_SI = 1'b0;
    start_query(q1);
    wait_result(lat);
    l = LabelOut_DO;
    d = DistanceOut_DO;
    n_checks++;
    if (l !== LW'(e1l) || d !== DW'(e1d)) begin
      n_fail++;
      $display("FAIL bp_result: label=%0d dist=%0d, required %0d %0d", l, d, e1l, e1d);
    end
    ValidIn_SI = 1'b1;
    HypervectorIn_DI = q2;
    stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ValidOut_SO !== 1'b1 || LabelOut_DO !== l || DistanceOut_DO !== d || ReadyOut_SO !== 1'b0)
        stable = 1'b0;
    end
    n_checks++;
    if (stable !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stable: outputs moved under backpressure (valid=%b ready=%b label=%0d dist=%0d), required 1 0 %0d %0d",
               ValidOut_SO, ReadyOut_SO, LabelOut_DO, DistanceOut_DO, l, d);
    end
    ReadyIn_SI = 1'b1;
    tick();
    n_checks++;
    if (ValidOut_SO !== 1'b0 || ReadyOut_SO !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_handshake: valid=%b ready=%b, required 0 1", ValidOut_SO, ReadyOut_SO);
    end
    tick();
    ValidIn_SI = 1'b0;
    wait_result(lat);
    n_checks++;
    if (lat != NC || LabelOut_DO !== LW'(e2l) || DistanceOut_DO !== DW'(e2d)) begin
      n_fail++;
      $display("FAIL bp_second: lat=%0d label=%0d dist=%0d, required %0d %0d %0d",
               lat, LabelOut_DO, DistanceOut_DO, NC, e2l, e2d);
    end
    tick();
  endtask

  task automatic test_write_during_search();
    logic [0:HV-1] q;
    int el, ed, lat;
    for (int c = 0; c < NC; c++) write_proto(c, rand_hv());
    q = rand_hv();
    model_search(q, el, ed);
    ReadyIn_SI = 1'b0;
    start_query(q);
    tick();
    ProtoWrEn_SI   = 1'b1;
    ProtoWrAddr_DI = LW'(0);
    ProtoWrData_DI = q;
    tick();
    tick();
    ProtoWrEn_SI = 1'b0;
    wait_result(lat);
    n_checks++;
    if (LabelOut_DO !== LW'(el) || DistanceOut_DO !== DW'(ed)) begin
      n_fail++;
      $display("FAIL wr_search_ignored: label=%0d dist=%0d, required %0d %0d", LabelOut_DO, DistanceOut_DO, el, ed);
    end
    // A write held while the result waits in DONE is dropped as well.
    ProtoWrEn_SI   = 1'b1;
    ProtoWrAddr_DI = LW'(1);
    ProtoWrData_DI = q;
    tick();
    tick();
    ProtoWrEn_SI = 1'b0;
    ReadyIn_SI = 1'b1;
    tick();
    start_query(q);
    wait_result(lat);
    n_checks++;
    if (LabelOut_DO !== LW'(el) || DistanceOut_DO !== DW'(ed)) begin
      n_fail++;
      $display("FAIL wr_done_ignored: label=%0d dist=%0d, required %0d %0d", LabelOut_DO, DistanceOut_DO, el, ed);
    end
    tick();
    write_proto(0, q);
    model_search(q, el, ed);
    start_query(q);
    wait_result(lat);
    n_checks++;
    if (LabelOut_DO !== LW'(0) || DistanceOut_DO !== DW'(0) || el != 0 || ed != 0) begin
      n_fail++;
      $display("FAIL wr_idle_applied: label=%0d dist=%0d, required 0 0", LabelOut_DO, DistanceOut_DO);
    end
    tick();
  endtask

  task automatic test_write_with_accept();
    logic [0:HV-1] q;
    int el, ed, lat;
    q = rand_hv();
    ProtoWrEn_SI     = 1'b1;
    ProtoWrAddr_DI   = LW'(NC - 1);
    ProtoWrData_DI   = q;
    ValidIn_SI       = 1'b1;
    HypervectorIn_DI = q;
    tick();
    ProtoWrEn_SI = 1'b0;
    ValidIn_SI   = 1'b0;
    model_proto[NC - 1] = q;
    model_search(q, el, ed);
    wait_result(lat);
    n_checks++;
    if (LabelOut_DO !== LW'(el) || DistanceOut_DO !== DW'(0)) begin
      n_fail++;
      $display("FAIL wr_same_cycle: label=%0d dist=%0d, required %0d 0", LabelOut_DO, DistanceOut_DO, el);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [0:HV-1] q;
    int el, ed, lat;
    q = rand_hv();
    start_query(q);
    tick();
    tick();
    Reset_RI = 1'b1;
    tick();
    Reset_RI = 1'b0;
    for (int c = 0; c < NC; c++) model_proto[c] = '0;
    n_checks++;
    if (ValidOut_SO !== 1'b0 || ReadyOut_SO !== 1'b1 || LabelOut_DO !== '0 || DistanceOut_DO !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_state: valid=%b ready=%b label=%0d dist=%0d, required 0 1 0 0",
               ValidOut_SO, ReadyOut_SO, LabelOut_DO, DistanceOut_DO);
    end
    model_search(q, el, ed);
    start_query(q);
    wait_result(lat);
    n_checks++;
    if (LabelOut_DO !== LW'(el) || DistanceOut_DO !== DW'($countones(q))) begin
      n_fail++;
      $display("FAIL reset_mid_protos: label=%0d dist=%0d, required %0d %0d",
               LabelOut_DO, DistanceOut_DO, el, $countones(q));
    end
    tick();
  endtask

`ifdef AM_REJECT_EN
  task automatic test_reject();
    int lat;
    for (int c = 0; c < NC; c++) write_proto(c, '0);
    start_query(ones_prefix(150));
    wait_result(lat);
    n_checks++;
    if (LabelOut_DO !== LW'(NC) || DistanceOut_DO !== DW'(150)) begin
      n_fail++;
      $display("FAIL reject_above: label=%0d dist=%0d, required %0d 150", LabelOut_DO, DistanceOut_DO, NC);
    end
    tick();
    start_query(ones_prefix(THR));
    wait_result(lat);
    n_checks++;
    if (LabelOut_DO !== LW'(0) || DistanceOut_DO !== DW'(THR)) begin
      n_fail++;
      $display("FAIL reject_at_threshold: label=%0d dist=%0d, required 0 %0d", LabelOut_DO, DistanceOut_DO, THR);
    end
    tick();
  endtask
`endif

  initial begin
    Reset_RI         = 1'b1;
    ValidIn_SI       = 1'b0;
    HypervectorIn_DI = '0;
    ProtoWrEn_SI     = 1'b0;
    ProtoWrAddr_DI   = '0;
    ProtoWrData_DI   = '0;
    ReadyIn_SI       = 1'b1;
    test_reset();
    test_spec_vector();
    test_tie();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_write_during_search();
    test_write_with_accept();
    test_reset_mid();
`ifdef AM_REJECT_EN
    test_reject();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
